aer_sender_rr: RTL and testbench

- Parametrised next-generation AER event sender for the FinalAERProtocol link.
- Accepts single-cycle event pulses from NUM_CH sources, each with a polarity (Up/Down).
- Picks pending events round-robin and serialises each one as a frame: Fs, ADDR_W address bits, polarity bit, Fe.
- Transmits over the two-wire 1-of-2 return-to-zero link (bit0/bit1) with a four-phase ack, and adds an ack timeout and drop reporting.

---
 rtl/aer_pkg.sv | 29 ++
 rtl/aer_rr_arbiter.sv | 39 +++
 rtl/aer_sender_rr.sv | 226 ++++++++++++++++++++++
 tb/tb_aer_sender_rr.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// Shared definitions for the AER round-robin sender: link codes, FSM states
// and a width helper.
package aer_pkg;

  localparam logic [1:0] SPACER = 2'b00;
  localparam logic [1:0] D0     = 2'b01;
  localparam logic [1:0] D1     = 2'b10;
  localparam logic [1:0] MARK   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_SPACER  = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_ABORT   = 3'd5
  } aer_state_e;

  // ceil(log2(n)), never below 1 so a field always has at least one bit
  function automatic int aer_clog2_min1(input int n);
    int r;
    r = 0;
    for (int w = 0; w < 31; w++) begin
      if ((32'sd1 <<< w) < n) r = w + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/aer_rr_arbiter.sv
// Combinational round-robin picker: first set bit of i_pending at or after
// i_rr_ptr, wrapping at NUM_CH.
module aer_rr_arbiter
  import aer_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]                       i_pending,
  input  logic [aer_clog2_min1(NUM_CH)-1:0]       i_rr_ptr,
  output logic                                    o_grant_valid,
  output logic [aer_clog2_min1(NUM_CH)-1:0]       o_grant_idx
);

  localparam int ADDR_W = aer_clog2_min1(NUM_CH);

  logic [NUM_CH-1:0] w_rot;
  int                w_sum;

  // bit k of w_rot is channel (rr_ptr + k) mod NUM_CH
  assign w_rot = NUM_CH'({i_pending, i_pending} >> i_rr_ptr);

  // lowest set bit of the rotated vector, mapped back to a channel number
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_sum         = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!o_grant_valid && w_rot[k]) begin
        o_grant_valid = 1'b1;
        w_sum = int'(i_rr_ptr) + k;
        if (w_sum >= NUM_CH) w_sum = w_sum - NUM_CH;
        o_grant_idx = ADDR_W'(w_sum);
      end else begin
        o_grant_valid = o_grant_valid;
      end
    end
  end

endmodule

// File: rtl/aer_sender_rr.sv
// Round-robin AER event sender: frames Fs/address/polarity/Fe onto a 1-of-2
// return-to-zero link with four-phase ack, ack timeout and drop reporting.
module aer_sender_rr
  import aer_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ev_req,
  input  logic [NUM_CH-1:0] ev_pol,
  input  logic              ack,
  output logic              bit0,
  output logic              bit1,
  output logic              busy,
  output logic              frame_done,
  output logic              ev_drop,
  output logic              timeout_err
);

  localparam int ADDR_W = aer_clog2_min1(NUM_CH);
  localparam int NSYM   = ADDR_W + 3;
  localparam int SYM_W  = aer_clog2_min1(NSYM);
  localparam int TMO_W  = aer_clog2_min1(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? TMO_W'(TIMEOUT_CYC - 1) : '0;

  logic              r_ack_meta, r_ack_s;
  logic [NUM_CH-1:0] r_pending, r_pol_q;
  logic [ADDR_W-1:0] r_rr_ptr, r_chan;
  logic              r_pol;
  aer_state_e        r_state, w_state_nxt;
  logic [SYM_W-1:0]  r_sym, w_sym_nxt;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [1:0]        r_rails, w_rails_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_drop;
  logic              r_tmo_err, w_tmo_err_nxt;
  logic              w_grant_valid, w_grant_fire, w_tmo_hit, w_last_sym;
  logic [ADDR_W-1:0] w_grant_idx;
  logic [NUM_CH-1:0] w_clr, w_held, w_drop_vec, w_pend_nxt, w_pol_nxt;

  // Code for symbol k: marks at both ends, address MSB first, then polarity
  function automatic logic [1:0] code_at(input logic [SYM_W-1:0] k,
                                         input logic [ADDR_W-1:0] chan,
                                         input logic pol);
    int   ki;
    logic b;
    ki = int'(k);
    if (ki == 0 || ki == ADDR_W + 2) begin
      return MARK;
    end else if (ki == ADDR_W + 1) begin
      return pol ? D1 : D0;
    end else begin
      b = |(chan & (ADDR_W'(1) << (ADDR_W - ki)));
      return b ? D1 : D0;
    end
  endfunction

  aer_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .i_pending    (r_pending),
    .i_rr_ptr     (r_rr_ptr),
    .o_grant_valid(w_grant_valid),
    .o_grant_idx  (w_grant_idx)
  );

  assign w_grant_fire = (r_state == ST_IDLE) && w_grant_valid;
  assign w_last_sym   = (r_sym == SYM_W'(NSYM - 1));
  assign w_tmo_hit    = (TIMEOUT_CYC != 0) &&
                        ((r_state == ST_WAIT_HI) || (r_state == ST_WAIT_LO)) &&
                        (r_tmo_cnt == TMO_LAST);

  // Event capture: a granted channel frees its slot the same cycle, so a
  // coinciding new event re-arms it instead of being dropped
  always_comb begin
    w_clr      = '0;
    w_held     = '0;
    w_drop_vec = '0;
    w_pend_nxt = '0;
    w_pol_nxt  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_clr[i]      = w_grant_fire && (w_grant_idx == ADDR_W'(i));
      w_held[i]     = r_pending[i] & ~w_clr[i];
      w_drop_vec[i] = ev_req[i] & w_held[i];
      w_pend_nxt[i] = ev_req[i] | w_held[i];
      if (ev_req[i] && !w_held[i]) w_pol_nxt[i] = ev_pol[i];
      else                         w_pol_nxt[i] = r_pol_q[i];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_grant_valid) w_state_nxt = ST_SEND;
                  else               w_state_nxt = ST_IDLE;
      ST_SEND:    w_state_nxt = ST_WAIT_HI;
      ST_WAIT_HI: if (w_tmo_hit)     w_state_nxt = ST_ABORT;
                  else if (r_ack_s)  w_state_nxt = ST_SPACER;
                  else               w_state_nxt = ST_WAIT_HI;
      ST_SPACER:  w_state_nxt = ST_WAIT_LO;
      ST_WAIT_LO: if (w_tmo_hit)     w_state_nxt = ST_ABORT;
                  else if (!r_ack_s) w_state_nxt = w_last_sym ? ST_IDLE : ST_SEND;
                  else               w_state_nxt = ST_WAIT_LO;
      ST_ABORT:   if (!r_ack_s)      w_state_nxt = ST_IDLE;
                  else               w_state_nxt = ST_ABORT;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output logic: next values for the registered link and status outputs
  always_comb begin
    w_rails_nxt   = r_rails;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_tmo_err_nxt = r_tmo_err;
    w_sym_nxt     = r_sym;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_rails_nxt = MARK;
          w_busy_nxt  = 1'b1;
          w_sym_nxt   = '0;
        end else begin
          w_rails_nxt = SPACER;
        end
      end
      ST_SEND, ST_SPACER: w_rails_nxt = r_rails;
      ST_WAIT_HI: begin
        if (w_tmo_hit) begin
          w_rails_nxt   = SPACER;
          w_tmo_err_nxt = 1'b1;
        end else if (r_ack_s) begin
          w_rails_nxt = SPACER;
        end else begin
          w_rails_nxt = r_rails;
        end
      end
      ST_WAIT_LO: begin
        if (w_tmo_hit) begin
          w_rails_nxt   = SPACER;
          w_tmo_err_nxt = 1'b1;
        end else if (!r_ack_s && w_last_sym) begin
          w_done_nxt = 1'b1;
          w_busy_nxt = 1'b0;
        end else if (!r_ack_s) begin
          w_sym_nxt   = r_sym + SYM_W'(1);
          w_rails_nxt = code_at(r_sym + SYM_W'(1), r_chan, r_pol);
        end else begin
          w_rails_nxt = r_rails;
        end
      end
      ST_ABORT: begin
        w_rails_nxt = SPACER;
        if (!r_ack_s) w_busy_nxt = 1'b0;
        else          w_busy_nxt = r_busy;
      end
      default: begin
        w_rails_nxt = SPACER;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Output, frame and capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
      r_pending  <= '0;
      r_pol_q    <= '0;
      r_rr_ptr   <= '0;
      r_chan     <= '0;
      r_pol      <= 1'b0;
      r_sym      <= '0;
      r_rails    <= SPACER;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
      r_tmo_err  <= 1'b0;
    end else begin
      r_ack_meta <= ack;
      r_ack_s    <= r_ack_meta;
      r_pending  <= w_pend_nxt;
      r_pol_q    <= w_pol_nxt;
      r_sym      <= w_sym_nxt;
      r_rails    <= w_rails_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_drop     <= |w_drop_vec;
      r_tmo_err  <= w_tmo_err_nxt;
      if (w_grant_fire) begin
        r_chan   <= w_grant_idx;
        r_pol    <= r_pol_q[w_grant_idx];
        r_rr_ptr <= (w_grant_idx == ADDR_W'(NUM_CH - 1)) ? '0 : w_grant_idx + ADDR_W'(1);
      end else begin
        r_chan   <= r_chan;
        r_pol    <= r_pol;
        r_rr_ptr <= r_rr_ptr;
      end
    end
  end

  // Ack-phase timer, restarted on every state change
  always_ff @(posedge clk) begin
    if (reset)                                                 r_tmo_cnt <= '0;
    else if (w_state_nxt != r_state)                           r_tmo_cnt <= '0;
    else if (r_state == ST_WAIT_HI || r_state == ST_WAIT_LO)   r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    else                                                       r_tmo_cnt <= r_tmo_cnt;
  end

  assign bit0        = r_rails[0];
  assign bit1        = r_rails[1];
  assign busy        = r_busy;
  assign frame_done  = r_done;
  assign ev_drop     = r_drop;
  assign timeout_err = r_tmo_err;

endmodule

// File: tb/tb_aer_sender_rr.sv
// Directed bench for aer_sender_rr: three instances (4, 2 and 5 channels) with a
// behavioural four-phase receiver and a symbol logger per instance.
module tb_aer_sender_rr;

  localparam logic [1:0] S = 2'b00;
  localparam logic [1:0] Z = 2'b01;
  localparam logic [1:0] O = 2'b10;
  localparam logic [1:0] M = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ev_req4, ev_pol4;
  logic [1:0] ev_req2, ev_pol2;
  logic [4:0] ev_req5, ev_pol5;
  logic [2:0] ack_v;
  logic [5:0] rails_f;
  logic [2:0] busy_v, done_v, drop_v, tmo_v;
  bit   [2:0] ack_en = 3'b111;

  logic [63:0] log_v [3];
  int          log_n [3];
  int          done_n[3];
  int          drop_n[3];
  int          nz_n  [3];
  int          bad_n [3];
  int          ack_cnt[3];
  logic [1:0]  prev  [3];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  aer_sender_rr #(.NUM_CH(4), .TIMEOUT_CYC(16)) u4 (
    .clk(clk), .reset(reset), .ev_req(ev_req4), .ev_pol(ev_pol4), .ack(ack_v[0]),
    .bit0(rails_f[0]), .bit1(rails_f[1]), .busy(busy_v[0]), .frame_done(done_v[0]),
    .ev_drop(drop_v[0]), .timeout_err(tmo_v[0]));

  aer_sender_rr #(.NUM_CH(2)) u2 (
    .clk(clk), .reset(reset), .ev_req(ev_req2), .ev_pol(ev_pol2), .ack(ack_v[1]),
    .bit0(rails_f[2]), .bit1(rails_f[3]), .busy(busy_v[1]), .frame_done(done_v[1]),
    .ev_drop(drop_v[1]), .timeout_err(tmo_v[1]));

  aer_sender_rr #(.NUM_CH(5)) u5 (
    .clk(clk), .reset(reset), .ev_req(ev_req5), .ev_pol(ev_pol5), .ack(ack_v[2]),
    .bit0(rails_f[4]), .bit1(rails_f[5]), .busy(busy_v[2]), .frame_done(done_v[2]),
    .ev_drop(drop_v[2]), .timeout_err(tmo_v[2]));

  // Receiver model and logger: ack follows the rails 4 cycles late; each rail change is logged
  initial begin
    ack_v = 3'b000;
    for (int d = 0; d < 3; d++) begin
      log_v[d] = '0; log_n[d] = 0; done_n[d] = 0; drop_n[d] = 0;
      nz_n[d] = 0; bad_n[d] = 0; ack_cnt[d] = 0; prev[d] = S;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        logic [1:0] r;
        r = rails_f[2*d +: 2];
        if (r != prev[d]) begin
          if (prev[d] != S && r != S) bad_n[d]++;
          log_v[d] = {log_v[d][61:0], r};
          log_n[d]++;
          prev[d] = r;
        end
        if (r != S) nz_n[d]++;
        if (done_v[d]) done_n[d]++;
        if (drop_v[d]) drop_n[d]++;
        if (!ack_en[d]) begin
          ack_v[d] = 1'b0; ack_cnt[d] = 0;
        end else if ((r != S) != ack_v[d]) begin
          ack_cnt[d]++;
          if (ack_cnt[d] == 4) begin ack_v[d] = ~ack_v[d]; ack_cnt[d] = 0; end
        end else begin
          ack_cnt[d] = 0;
        end
      end
    end
  end

  task automatic pulse(input int d, input logic [7:0] req, input logic [7:0] pol);
    @(negedge clk);
    case (d)
      0: begin ev_req4 = req[3:0]; ev_pol4 = pol[3:0]; end
      1: begin ev_req2 = req[1:0]; ev_pol2 = pol[1:0]; end
      default: begin ev_req5 = req[4:0]; ev_pol5 = pol[4:0]; end
    endcase
    @(negedge clk);
    ev_req4 = '0; ev_req2 = '0; ev_req5 = '0;
  endtask

  task automatic wait_done(input int d, input int target);
    for (int c = 0; c < 2000 && done_n[d] < target; c++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++; if (rails_f[2*d +: 2] !== S) $display("FAIL reset_rails dut%0d got %b exp 00", d, rails_f[2*d +: 2]); else passed++;
      checks++; if ({busy_v[d], done_v[d], drop_v[d], tmo_v[d]} !== 4'b0000)
        $display("FAIL reset_status dut%0d got %b exp 0000", d, {busy_v[d], done_v[d], drop_v[d], tmo_v[d]}); else passed++;
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int n0, d0;
    logic [63:0] exp, got;
    n0 = log_n[0]; d0 = done_n[0];
    pulse(0, 8'b0100, 8'b0100);
    checks++; if ({rails_f[1:0], busy_v[0]} !== 3'b000) $display("FAIL single_cycle1 got %b exp 000", {rails_f[1:0], busy_v[0]}); else passed++;
    @(negedge clk);
    checks++; if ({rails_f[1:0], busy_v[0]} !== 3'b111) $display("FAIL single_fs_latency got %b exp 111", {rails_f[1:0], busy_v[0]}); else passed++;
    wait_done(0, d0 + 1);
    repeat (10) @(negedge clk);
    exp = 64'({M, S, O, S, Z, S, O, S, M, S});
    got = log_v[0] & ((64'd1 << 20) - 64'd1);
    checks++; if (log_n[0] - n0 !== 10) $display("FAIL single_len got %0d exp 10", log_n[0] - n0); else passed++;
    checks++; if (got !== exp) $display("FAIL single_frame got %h exp %h", got, exp); else passed++;
    checks++; if (done_n[0] - d0 !== 1) $display("FAIL single_done got %0d exp 1", done_n[0] - d0); else passed++;
    checks++; if (busy_v[0] !== 1'b0) $display("FAIL single_busy_after got %b exp 0", busy_v[0]); else passed++;
  endtask

  task automatic test_round_robin();
    int n0, d0, p0;
    logic [63:0] exp, got;
    do_reset();
    p0 = drop_n[0];
    for (int round = 0; round < 2; round++) begin
      n0 = log_n[0]; d0 = done_n[0];
      if (round == 0) begin
        pulse(0, 8'b1001, 8'b0001);
        exp = 64'({M, S, Z, S, Z, S, O, S, M, S, M, S, O, S, O, S, Z, S, M, S});
      end else begin
        pulse(0, 8'b1001, 8'b1000);
        exp = 64'({M, S, Z, S, Z, S, Z, S, M, S, M, S, O, S, O, S, O, S, M, S});
      end
      wait_done(0, d0 + 2);
      got = log_v[0] & ((64'd1 << 40) - 64'd1);
      checks++; if (log_n[0] - n0 !== 20) $display("FAIL rr_len round%0d got %0d exp 20", round, log_n[0] - n0); else passed++;
      checks++; if (got !== exp) $display("FAIL rr_order round%0d got %h exp %h", round, got, exp); else passed++;
    end
    checks++; if (drop_n[0] - p0 !== 0) $display("FAIL rr_no_drop got %0d exp 0", drop_n[0] - p0); else passed++;
  endtask

  task automatic test_drop();
    int n0, d0, p0;
    logic [63:0] exp, got;
    do_reset();
    n0 = log_n[0]; d0 = done_n[0]; p0 = drop_n[0];
    pulse(0, 8'b0001, 8'b0000);
    pulse(0, 8'b0010, 8'b0010);
    pulse(0, 8'b0010, 8'b0000);
    wait_done(0, d0 + 2);
    repeat (40) @(negedge clk);
    exp = 64'({M, S, Z, S, Z, S, Z, S, M, S, M, S, Z, S, O, S, O, S, M, S});
    got = log_v[0] & ((64'd1 << 40) - 64'd1);
    checks++; if (drop_n[0] - p0 !== 1) $display("FAIL drop_pulses got %0d exp 1", drop_n[0] - p0); else passed++;
    checks++; if (done_n[0] - d0 !== 2) $display("FAIL drop_frames got %0d exp 2", done_n[0] - d0); else passed++;
    checks++; if (log_n[0] - n0 !== 20) $display("FAIL drop_len got %0d exp 20", log_n[0] - n0); else passed++;
    checks++; if (got !== exp) $display("FAIL drop_first_pol got %h exp %h", got, exp); else passed++;
  endtask

  task automatic test_timeout();
    int d0, n0, n11;
    logic [63:0] exp, got;
    do_reset();
    d0 = done_n[0];
    ack_en[0] = 1'b0;
    pulse(0, 8'b0010, 8'b0000);
    n11 = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rails_f[1:0] == M) n11++;
      else if (n11 > 0) break;
    end
    checks++; if (n11 !== 17) $display("FAIL tmo_fs_hold got %0d cycles exp 17", n11); else passed++;
    checks++; if ({rails_f[1:0], tmo_v[0]} !== 3'b001) $display("FAIL tmo_abort got %b exp 001", {rails_f[1:0], tmo_v[0]}); else passed++;
    @(negedge clk);
    checks++; if (busy_v[0] !== 1'b0) $display("FAIL tmo_busy got %b exp 0", busy_v[0]); else passed++;
    checks++; if (done_n[0] - d0 !== 0) $display("FAIL tmo_no_done got %0d exp 0", done_n[0] - d0); else passed++;
    ack_en[0] = 1'b1;
    repeat (4) @(negedge clk);
    n0 = log_n[0];
    pulse(0, 8'b1000, 8'b1000);
    wait_done(0, d0 + 1);
    exp = 64'({M, S, O, S, O, S, O, S, M, S});
    got = log_v[0] & ((64'd1 << 20) - 64'd1);
    checks++; if (log_n[0] - n0 !== 10) $display("FAIL tmo_next_len got %0d exp 10", log_n[0] - n0); else passed++;
    checks++; if (got !== exp) $display("FAIL tmo_next_frame got %h exp %h", got, exp); else passed++;
    checks++; if (tmo_v[0] !== 1'b1) $display("FAIL tmo_sticky got %b exp 1", tmo_v[0]); else passed++;
  endtask

  task automatic test_reset_mid();
    int n0, d0, z0;
    do_reset();
    n0 = log_n[0];
    pulse(0, 8'b0100, 8'b0000);
    pulse(0, 8'b0010, 8'b0010);
    for (int c = 0; c < 200 && log_n[0] < n0 + 3; c++) @(negedge clk);
    checks++; if (rails_f[1:0] !== O) $display("FAIL mid_addr_phase got %b exp 10", rails_f[1:0]); else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({rails_f[1:0], busy_v[0]} !== 3'b000) $display("FAIL mid_reset got %b exp 000", {rails_f[1:0], busy_v[0]}); else passed++;
    reset = 1'b0;
    z0 = nz_n[0]; d0 = done_n[0];
    repeat (60) @(negedge clk);
    checks++; if (nz_n[0] - z0 !== 0) $display("FAIL mid_rails_quiet got %0d active cycles exp 0", nz_n[0] - z0); else passed++;
    checks++; if ({busy_v[0], tmo_v[0]} !== 2'b00) $display("FAIL mid_status got %b exp 00", {busy_v[0], tmo_v[0]}); else passed++;
    checks++; if (done_n[0] - d0 !== 0) $display("FAIL mid_no_done got %0d exp 0", done_n[0] - d0); else passed++;
  endtask

  task automatic test_sizes();
    int n1, n2, d1, d2;
    logic [63:0] exp, got;
    n1 = log_n[1]; d1 = done_n[1];
    pulse(1, 8'b10, 8'b00);
    wait_done(1, d1 + 1);
    exp = 64'({M, S, O, S, Z, S, M, S});
    got = log_v[1] & ((64'd1 << 16) - 64'd1);
    checks++; if (log_n[1] - n1 !== 8) $display("FAIL size2_len got %0d exp 8", log_n[1] - n1); else passed++;
    checks++; if (got !== exp) $display("FAIL size2_frame got %h exp %h", got, exp); else passed++;
    n2 = log_n[2]; d2 = done_n[2];
    pulse(2, 8'b10000, 8'b10000);
    wait_done(2, d2 + 1);
    exp = 64'({M, S, O, S, Z, S, Z, S, O, S, M, S});
    got = log_v[2] & ((64'd1 << 24) - 64'd1);
    checks++; if (log_n[2] - n2 !== 12) $display("FAIL size5_len got %0d exp 12", log_n[2] - n2); else passed++;
    checks++; if (got !== exp) $display("FAIL size5_frame got %h exp %h", got, exp); else passed++;
    for (int d = 0; d < 3; d++) begin
      checks++; if (bad_n[d] !== 0) $display("FAIL rz_rule dut%0d got %0d exp 0", d, bad_n[d]); else passed++;
    end
  endtask

  initial begin
    reset = 1'b1;
    ev_req4 = '0; ev_pol4 = '0;
    ev_req2 = '0; ev_pol2 = '0;
    ev_req5 = '0; ev_pol5 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_timeout();
    test_reset_mid();
    test_sizes();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
